iter_div_unit: RTL

- Multi-cycle integer divide/remainder unit in the EX stage.
- Its result feeds the writeback result-select mux, on the input chosen for DIV/MOD instructions.
- Uses restoring division, one quotient bit per clock, with start/busy/done handshake to the pipeline hazard logic.
- Supports signed and unsigned quotient and remainder.

---
 rtl/iter_div_unit_pkg.sv | 25 ++
 rtl/iter_div_unit_if.sv | 25 ++
 rtl/iter_div_unit_div_step.sv | 26 ++
 rtl/iter_div_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/iter_div_unit_pkg.sv
// Shared definitions for the iterative divide/remainder unit: op encodings,
// FSM state type and op decode helpers.
package iter_div_unit_pkg;

  localparam logic [1:0] DIV_S = 2'b00;
  localparam logic [1:0] DIV_U = 2'b01;
  localparam logic [1:0] MOD_S = 2'b10;
  localparam logic [1:0] MOD_U = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  function automatic logic op_is_mod(input logic [1:0] op);
    return (op == MOD_S) || (op == MOD_U);
  endfunction

  function automatic logic op_is_unsigned(input logic [1:0] op);
    return (op == DIV_U) || (op == MOD_U);
  endfunction

endpackage

// File: rtl/iter_div_unit_if.sv
// Pipeline-side handshake bundle for the divide unit: request, abort and result.
interface iter_div_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src0;
  logic [WIDTH-1:0] src1;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;

  modport master (
    output start, op, src0, src1, flush,
    input  busy, done, res
  );

  modport slave (
    input  start, op, src0, src1, flush,
    output busy, done, res
  );

endinterface

// File: rtl/iter_div_unit_div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the
// divisor and commit the difference when it does not go negative.
module iter_div_unit_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    // Partial remainder stays below the divisor, so bit WIDTH is the borrow.
    fits    = ~diff[WIDTH];
    rem_nx  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nx  = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle signed/unsigned divide and remainder for the EX stage.
// Restoring division on magnitudes, one quotient bit per clock, signs fixed at the end.
module iter_div_unit
  import iter_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rstn,
  iter_div_unit_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic             is_mod_q;
  logic             sign_q;
  logic             sign_r;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] res_q;

  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             src_uns;
  logic             src0_neg;
  logic             src1_neg;
  logic [WIDTH-1:0] src0_mag;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;

  // Negative flags are already zero for unsigned ops, so they double as sign_q/sign_r.
  always_comb begin
    src_uns  = op_is_unsigned(bus.op);
    src0_neg = ~src_uns & bus.src0[WIDTH-1];
    src1_neg = ~src_uns & bus.src1[WIDTH-1];
    src0_mag = src0_neg ? -bus.src0 : bus.src0;
    src1_mag = src1_neg ? -bus.src1 : bus.src1;
    rem_fix  = sign_r ? -rem_q : rem_q;
    quo_fix  = sign_q ? -quo_q : quo_q;
  end

  iter_div_unit_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .dvs    (dvs_q),
    .rem_nx (rem_nx),
    .quo_nx (quo_nx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      is_mod_q <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
    end else if (state != IDLE && bus.flush) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.flush) begin
            is_mod_q <= op_is_mod(bus.op);
            busy_q   <= 1'b1;
            if (bus.src1 == '0) begin
              res_q  <= op_is_mod(bus.op) ? bus.src0 : '1;
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              sign_q <= src0_neg ^ src1_neg;
              sign_r <= src0_neg;
              quo_q  <= src0_mag;
              dvs_q  <= src1_mag;
              rem_q  <= '0;
              cnt    <= '0;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= FIX;
          end
        end
        FIX: begin
          res_q  <= is_mod_q ? rem_fix : quo_fix;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;

endmodule
